// File: rtl/spi_pkg.sv
// Shared widths, opcodes, frame layout and state encoding for the SPI main controller.
package spi_pkg;

    localparam int unsigned FRAME_W = 44;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 32;

    localparam logic [OP_W-1:0] OP_READ  = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE = 2'b01;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT_OUT = 3'd1,
        ST_TURN      = 3'd2,
        ST_SHIFT_IN  = 3'd3,
        ST_RESP      = 3'd4,
        ST_GAP       = 3'd5
    } spi_main_state_e;

endpackage

// File: rtl/spi_main_ctrl_if.sv
// Request/response handshake bundle between on-chip requesters and the SPI main controller.
interface spi_main_ctrl_if;
    import spi_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [OP_W-1:0]     req_op;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [FRAME_W-1:0]  rsp_frame;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_frame, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_frame, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/spi_shreg.sv
// MSB-first shift register with parallel load; load wins over shift.
module spi_shreg
    import spi_pkg::*;
#(
    parameter int unsigned W = FRAME_W
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         sin,
    output logic         sout,
    output logic [W-1:0] pout
);

    logic [W-1:0] q;

    always_ff @(posedge sclk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

    assign sout = q[W-1];
    assign pout = q;

endmodule

// File: rtl/spi_main_ctrl.sv
// SPI main controller: one 44-bit command frame out, turnaround, one 44-bit response frame in,
// echo check, then a held response handshake.
module spi_main_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic            sclk,
    input  logic            rst,
    spi_main_ctrl_if.slave  bus,
    output logic            cs_n,
    output logic            mosi,
    input  logic            miso,
    output logic            busy
);

    localparam int unsigned CNT_W = 7;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_SHIFT_OUT = ST_SHIFT_OUT;
    localparam logic [2:0] S_TURN      = ST_TURN;
    localparam logic [2:0] S_SHIFT_IN  = ST_SHIFT_IN;
    localparam logic [2:0] S_RESP      = ST_RESP;
    localparam logic [2:0] S_GAP       = ST_GAP;

    logic [2:0]         state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               tx_load, tx_shift, rx_shift, rsp_capture;
    logic               req_ready_q, rsp_valid_q, rsp_err_q, cs_n_q, busy_q;
    logic [FRAME_W-1:0] rsp_frame_q;
    logic [OP_W-1:0]    sent_op_q;
    logic [ADDR_W-1:0]  sent_addr_q;
    logic [FRAME_W-1:0] tx_pout, rx_pout;
    logic               rx_sout;
    spi_frame_t         req_frame, rx_frame;

    assign req_frame = {bus.req_op, bus.req_addr, bus.req_wdata};
    // Frame as it will look once the bit on miso this cycle is shifted in.
    assign rx_frame  = {rx_pout[FRAME_W-2:0], miso};

    spi_shreg #(.W(FRAME_W)) u_tx (
        .sclk     (sclk),
        .rst      (rst),
        .load     (tx_load),
        .load_val (req_frame),
        .shift_en (tx_shift),
        .sin      (1'b0),
        .sout     (mosi),
        .pout     (tx_pout)
    );

    spi_shreg #(.W(FRAME_W)) u_rx (
        .sclk     (sclk),
        .rst      (rst),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (rx_shift),
        .sin      (miso),
        .sout     (rx_sout),
        .pout     (rx_pout)
    );

    logic unused_ok;
    assign unused_ok = ^{tx_pout, rx_sout};

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next state, shared cycle counter and datapath strobes.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        rx_shift    = 1'b0;
        rsp_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_nxt = '0;
                if (bus.req_valid && req_ready_q) begin
                    tx_load   = 1'b1;
                    state_nxt = S_SHIFT_OUT;
                end
            end
            S_SHIFT_OUT: begin
                tx_shift = 1'b1;
                cnt_nxt  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_nxt   = '0;
                    state_nxt = S_TURN;
                end
            end
            S_TURN: begin
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_TURN) begin
                    cnt_nxt   = '0;
                    state_nxt = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                rx_shift = 1'b1;
                cnt_nxt  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    rsp_capture = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                cnt_nxt = '0;
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_GAP) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered so they line up with it.
    always_ff @(posedge sclk) begin
        if (rst) begin
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_frame_q <= '0;
            rsp_err_q   <= 1'b0;
            sent_op_q   <= '0;
            sent_addr_q <= '0;
        end else begin
            cs_n_q      <= !(state_nxt inside {S_SHIFT_OUT, S_TURN, S_SHIFT_IN});
            busy_q      <= (state_nxt != S_IDLE);
            req_ready_q <= (state_nxt == S_IDLE);
            rsp_valid_q <= (state_nxt == S_RESP);
            if (tx_load) begin
                sent_op_q   <= bus.req_op;
                sent_addr_q <= bus.req_addr;
            end
            if (rsp_capture) begin
                rsp_frame_q <= rx_frame;
                rsp_err_q   <= (rx_frame.op != sent_op_q) || (rx_frame.addr != sent_addr_q);
            end
        end
    end

    assign cs_n          = cs_n_q;
    assign busy          = busy_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_frame = rsp_frame_q;
    assign bus.rsp_rdata = rsp_frame_q[DATA_W-1:0];
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_spi_main_ctrl.sv
// Directed bench for spi_main_ctrl with a behavioural spi_sub memory model on the serial side.
module tb_spi_main_ctrl;
    import spi_pkg::*;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    logic miso = 1'b0;
    logic cs_n, mosi, busy;

    spi_main_ctrl_if bus();

    spi_main_ctrl dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus),
        .cs_n (cs_n),
        .mosi (mosi),
        .miso (miso),
        .busy (busy)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // spi_sub model: 44 bits in, two idle turnaround cycles, 44 bits out.
    logic [31:0]        mem [0:1023];
    logic [FRAME_W-1:0] sub_rx, sub_rsp;
    int                 sub_cnt = 0;
    int                 sub_post = 0;
    logic               bad_echo = 1'b0;
    spi_frame_t         sub_f;
    logic [31:0]        sub_data;

    always @(posedge sclk) begin
        if (cs_n) begin
            sub_cnt  <= 0;
            sub_post <= 0;
            miso     <= 1'b0;
        end else if (sub_cnt < 44) begin
            sub_rx   <= {sub_rx[42:0], mosi};
            sub_cnt  <= sub_cnt + 1;
            sub_post <= 0;
            if (sub_cnt == 43) begin
                sub_f = {sub_rx[42:0], mosi};
                if (sub_f.op == OP_WRITE) begin
                    mem[sub_f.addr] = sub_f.data;
                    sub_data = sub_f.data;
                end else if (sub_f.op == OP_READ) begin
                    sub_data = mem[sub_f.addr];
                end else begin
                    sub_data = sub_f.data;
                end
                sub_rsp <= {sub_f.op, (bad_echo ? 10'h155 : sub_f.addr), sub_data};
            end
        end else begin
            sub_post <= sub_post + 1;
            if (sub_post >= 1 && sub_post <= 44) miso <= sub_rsp[44 - sub_post];
            else                                 miso <= 1'b0;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        bad;
        int          hold;
        logic [43:0] exp_frame;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    // One full transaction: handshake, mosi stream, timing, response, back-pressure, gap.
    task automatic do_txn(input vec_t v, input string tag);
        logic [43:0] tx_exp, mosi_got;
        int          j, lat, csl;
        bit          hold_ok, gap_ok;
        tx_exp   = {v.op, v.addr, v.wdata};
        bad_echo = v.bad;
        j = 0;
        while (!bus.req_ready && j < 200) begin
            @(negedge sclk);
            j++;
        end
        chk({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        @(posedge sclk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = ~v.op;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = ~v.wdata;
        lat = 0; csl = 0; mosi_got = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge sclk);
            if (k < 44) mosi_got = {mosi_got[42:0], mosi};
            if (!cs_n) csl++;
            if (bus.rsp_valid) begin
                lat = k + 1;
                break;
            end
        end
        chk({tag, ":mosi_stream"}, 64'(mosi_got), 64'(tx_exp));
        chk({tag, ":latency"}, 64'(lat), 64'd91);
        chk({tag, ":cs_low_cycles"}, 64'(csl), 64'd90);
        chk({tag, ":rsp_frame"}, 64'(bus.rsp_frame), 64'(v.exp_frame));
        chk({tag, ":rsp_rdata"}, 64'(bus.rsp_rdata), 64'(v.exp_frame[31:0]));
        chk({tag, ":rsp_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
        if (v.hold > 0) begin
            hold_ok = 1'b1;
            for (int h = 0; h < v.hold; h++) begin
                @(negedge sclk);
                if (!bus.rsp_valid || bus.rsp_frame !== v.exp_frame || bus.req_ready || cs_n !== 1'b1)
                    hold_ok = 1'b0;
            end
            chk({tag, ":hold_stable"}, 64'(hold_ok), 64'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge sclk);
        #1;
        bus.rsp_ready = 1'b0;
        gap_ok = 1'b1;
        j = 0;
        while (j < 20) begin
            @(negedge sclk);
            if (bus.req_ready) break;
            if (!cs_n || bus.rsp_valid) gap_ok = 1'b0;
            j++;
        end
        chk({tag, ":gap_cycles"}, 64'(j), 64'd2);
        chk({tag, ":gap_idle_bus"}, 64'(gap_ok), 64'd1);
    endtask

    initial begin
        vec_t v;
        bit   quiet;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        vecs[0] = '{op: 2'b01, addr: 10'h3FF, wdata: 32'hDEADBEEF, bad: 1'b0, hold: 0,  exp_frame: 44'h7FF_DEADBEEF, exp_err: 1'b0};
        vecs[1] = '{op: 2'b01, addr: 10'h000, wdata: 32'h12345678, bad: 1'b0, hold: 10, exp_frame: 44'h400_12345678, exp_err: 1'b0};
        vecs[2] = '{op: 2'b00, addr: 10'h000, wdata: 32'h00000000, bad: 1'b0, hold: 0,  exp_frame: 44'h000_12345678, exp_err: 1'b0};
        vecs[3] = '{op: 2'b00, addr: 10'h3FF, wdata: 32'h00000000, bad: 1'b0, hold: 3,  exp_frame: 44'h3FF_DEADBEEF, exp_err: 1'b0};
        vecs[4] = '{op: 2'b11, addr: 10'h0AA, wdata: 32'h0F0F0F0F, bad: 1'b0, hold: 0,  exp_frame: 44'hCAA_0F0F0F0F, exp_err: 1'b0};
        vecs[5] = '{op: 2'b01, addr: 10'h2AA, wdata: 32'hA5A50F0F, bad: 1'b1, hold: 4,  exp_frame: 44'h555_A5A50F0F, exp_err: 1'b1};
        vecs[6] = '{op: 2'b00, addr: 10'h2AA, wdata: 32'h00000000, bad: 1'b0, hold: 0,  exp_frame: 44'h2AA_A5A50F0F, exp_err: 1'b0};

        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge sclk);
        chk("reset:cs_n", 64'(cs_n), 64'd1);
        chk("reset:mosi", 64'(mosi), 64'd0);
        chk("reset:req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset:rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset:rsp_frame", 64'(bus.rsp_frame), 64'd0);
        chk("reset:rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset:busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge sclk);
        chk("post_reset:req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            do_txn(v, $sformatf("vec%0d", i));
        end

        // Reset during SHIFT_OUT cycle 20 of a write that must never land.
        bad_echo      = 1'b0;
        bus.req_op    = 2'b01;
        bus.req_addr  = 10'h3FF;
        bus.req_wdata = 32'h11111111;
        bus.req_valid = 1'b1;
        @(posedge sclk);
        #1;
        bus.req_valid = 1'b0;
        repeat (21) @(negedge sclk);
        chk("midrst:busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge sclk);
        chk("midrst:cs_n", 64'(cs_n), 64'd1);
        chk("midrst:mosi", 64'(mosi), 64'd0);
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:rsp_valid", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        @(negedge sclk);
        chk("midrst:req_ready", 64'(bus.req_ready), 64'd1);
        quiet = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge sclk);
            if (bus.rsp_valid || !cs_n || busy) quiet = 1'b0;
        end
        chk("midrst:no_partial_rsp", 64'(quiet), 64'd1);

        v = '{op: 2'b01, addr: 10'h3FF, wdata: 32'hCAFEBABE, bad: 1'b0, hold: 0, exp_frame: 44'h7FF_CAFEBABE, exp_err: 1'b0};
        do_txn(v, "after_rst_wr");
        v = '{op: 2'b00, addr: 10'h3FF, wdata: 32'h00000000, bad: 1'b0, hold: 0, exp_frame: 44'h3FF_CAFEBABE, exp_err: 1'b0};
        do_txn(v, "after_rst_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
